// File: rtl/node_launcher_if.sv
// AXI-lite bus bundle between a node launcher and the control block.
// Modports: master (launcher side), slave (control side).

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                   awprot;
    logic                         awvalid;
    logic                         awready;
    logic [`AXI_DATA_WIDTH-1:0]   wdata;
    logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                         wvalid;
    logic                         wready;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;
    logic [`AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                   arprot;
    logic                         arvalid;
    logic                         arready;
    logic [`AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/node_launcher.sv
// Per-node boot sequencer: polls PROG for a program offset, runs the
// core until core_done, then writes 0 to PROG to free the node.
// Ports: clk, res (sync active-high), m_axi (AXI-lite master),
//   core_res (1 = core in reset), core_offset, core_done, err (sticky).
// Optional NODE_LAUNCHER_COUNT_EN: after each run reads COUNT and
//   reports it on run_cycles with a one-cycle run_valid pulse.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef NUM_NODES_PROCESSING_WIDTH
`define NUM_NODES_PROCESSING_WIDTH 4
`endif

module node_launcher #(
    parameter int NODE_ID       = 0,
    parameter int NODE_W        = `NUM_NODES_PROCESSING_WIDTH,
    parameter int NODE_LSB      = 2,
    parameter int POLL_INTERVAL = 64,
    parameter logic [`AXI_ADDR_WIDTH-1:0] CTRL_BASE =
        {1'b1, {(`AXI_ADDR_WIDTH-1){1'b0}}}
) (
    input  logic                       clk,
    input  logic                       res,
    if_axi_light.master                m_axi,
    output logic                       core_res,
    output logic [`AXI_DATA_WIDTH-1:0] core_offset,
    input  logic                       core_done,
    output logic                       err
`ifdef NODE_LAUNCHER_COUNT_EN
    ,
    output logic [31:0]                run_cycles,
    output logic                       run_valid
`endif
);

    localparam int AW = `AXI_ADDR_WIDTH;
    localparam int DW = `AXI_DATA_WIDTH;
    localparam int CW = $clog2(POLL_INTERVAL + 1);

    localparam logic [NODE_W-1:0] ID = NODE_ID[NODE_W-1:0];
    localparam logic [AW-1:0] ID_BITS = AW'(ID) << NODE_LSB;
    localparam logic [AW-1:0] PROG_ADDR =
        CTRL_BASE | (AW'(1) << 7) | ID_BITS;
`ifdef NODE_LAUNCHER_COUNT_EN
    localparam logic [AW-1:0] COUNT_ADDR =
        CTRL_BASE | (AW'(1) << 9) | ID_BITS;
`endif

    typedef enum logic [2:0] {
        POLL_WAIT,
        RD_PROG,
        RD_PROG_RESP,
        RUN,
        WR_FIN,
        WR_FIN_RESP,
        RD_CNT,
        RD_CNT_RESP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          aw_done;
    logic          aw_done_n;
    logic          w_done;
    logic          w_done_n;

    logic r_hs;
    logic r_ok;
    logic b_hs;
    logic b_ok;

    assign r_hs = m_axi.rvalid && m_axi.rready;
    assign r_ok = (m_axi.rresp == 2'b00);
    assign b_hs = m_axi.bvalid && m_axi.bready;
    assign b_ok = (m_axi.bresp == 2'b00);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            POLL_WAIT: begin
                // Leaving when the count would hit 0 gives exactly
                // POLL_INTERVAL idle cycles before arvalid.
                if (cnt == CW'(1)) begin
                    cnt_n   = CW'(POLL_INTERVAL);
                    state_n = RD_PROG;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RD_PROG: begin
                if (m_axi.arready) state_n = RD_PROG_RESP;
            end
            RD_PROG_RESP: begin
                if (m_axi.rvalid) begin
                    if (r_ok && (m_axi.rdata != '0)) state_n = RUN;
                    else state_n = POLL_WAIT;
                end
            end
            RUN: begin
                if (core_done) state_n = WR_FIN;
            end
            WR_FIN: begin
                aw_done_n = aw_done || m_axi.awready;
                w_done_n  = w_done || m_axi.wready;
                if (aw_done_n && w_done_n) begin
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = WR_FIN_RESP;
                end
            end
            WR_FIN_RESP: begin
                if (m_axi.bvalid) begin
`ifdef NODE_LAUNCHER_COUNT_EN
                    state_n = b_ok ? RD_CNT : WR_FIN;
`else
                    state_n = b_ok ? POLL_WAIT : WR_FIN;
`endif
                end
            end
`ifdef NODE_LAUNCHER_COUNT_EN
            RD_CNT: begin
                if (m_axi.arready) state_n = RD_CNT_RESP;
            end
            RD_CNT_RESP: begin
                if (m_axi.rvalid) state_n = POLL_WAIT;
            end
`endif
            default: state_n = POLL_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= POLL_WAIT;
            cnt         <= CW'(POLL_INTERVAL);
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            core_offset <= '0;
            err         <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (state == RD_PROG_RESP && r_hs && r_ok
                && m_axi.rdata != '0) begin
                core_offset <= m_axi.rdata;
            end
            if ((r_hs && !r_ok) || (b_hs && !b_ok)) err <= 1'b1;
        end
    end

`ifdef NODE_LAUNCHER_COUNT_EN
    always_ff @(posedge clk) begin
        if (res) begin
            run_cycles <= '0;
            run_valid  <= 1'b0;
        end else begin
            run_valid <= 1'b0;
            if (state == RD_CNT_RESP && r_hs && r_ok) begin
                run_cycles <= 32'(m_axi.rdata);
                run_valid  <= 1'b1;
            end
        end
    end

    assign m_axi.arvalid = (state == RD_PROG) || (state == RD_CNT);
    assign m_axi.araddr  = (state == RD_CNT) ? COUNT_ADDR : PROG_ADDR;
    assign m_axi.rready  = (state == RD_PROG_RESP)
                        || (state == RD_CNT_RESP);
`else
    assign m_axi.arvalid = (state == RD_PROG);
    assign m_axi.araddr  = PROG_ADDR;
    assign m_axi.rready  = (state == RD_PROG_RESP);
`endif

    assign m_axi.arprot  = 3'b000;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awaddr  = PROG_ADDR;
    assign m_axi.awvalid = (state == WR_FIN) && !aw_done;
    assign m_axi.wvalid  = (state == WR_FIN) && !w_done;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '1;
    assign m_axi.bready  = (state == WR_FIN_RESP);
    assign core_res      = (state != RUN);

    logic unused_dw;
    assign unused_dw = (DW == 0);

endmodule

// File: tb/tb_node_launcher.sv
// Directed bench for node_launcher: reset, idle polling, launch,
// finish write, bresp retry, optional COUNT read, reset mid-run.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_node_launcher;

    localparam int P = 4;
    localparam logic [63:0] PROG = 64'h8000_008C;
    localparam logic [63:0] CNTA = 64'h8000_020C;

    logic clk = 1'b0;
    logic res = 1'b1;
    logic core_res;
    logic [`AXI_DATA_WIDTH-1:0] core_offset;
    logic core_done = 1'b0;
    logic err;
`ifdef NODE_LAUNCHER_COUNT_EN
    logic [31:0] run_cycles;
    logic run_valid;
`endif

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;

    if_axi_light axi ();

    node_launcher #(
        .NODE_ID(3),
        .POLL_INTERVAL(P)
    ) dut (
        .clk(clk),
        .res(res),
        .m_axi(axi),
        .core_res(core_res),
        .core_offset(core_offset),
        .core_done(core_done),
        .err(err)
`ifdef NODE_LAUNCHER_COUNT_EN
        ,
        .run_cycles(run_cycles),
        .run_valid(run_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!res && axi.awvalid && axi.awready
            && 64'(axi.awaddr) == PROG) aw_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] ar_seen;
        logic [17:0] r_seen;
        logic        wr_any;
        logic        cr_all;
        logic        av_any;
        int          n;

        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;

        step();
        step();
        chk("rst_core_res", 64'(core_res), 64'd1);
        chk("rst_offset", 64'(core_offset), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid,
            axi.rready, axi.bready}), 64'd0);

        // Idle polling: PROG reads return 0, core_done pulse ignored.
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = '0;
        res = 1'b0;
        ar_seen = '0;
        r_seen  = '0;
        wr_any  = 1'b0;
        cr_all  = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            ar_seen[k-1] = axi.arvalid;
            r_seen[k-1]  = axi.rready;
            wr_any = wr_any | axi.awvalid | axi.wvalid;
            cr_all = cr_all & core_res;
            core_done = (k == 2);
        end
        core_done = 1'b0;
        chk("idle_arvalid", 64'(ar_seen), 64'h0_8208);
        chk("idle_rready", 64'(r_seen), 64'h1_0410);
        chk("idle_no_write", 64'(wr_any), 64'd0);
        chk("idle_core_res", 64'(cr_all), 64'd1);

        // Launch with delayed arready.
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0001_0000;
        step();
        step();
        step();
        step();
        chk("ar_valid", 64'(axi.arvalid), 64'd1);
        chk("ar_addr", 64'(axi.araddr), PROG);
        chk("ar_prot", 64'(axi.arprot), 64'd0);
        step();
        chk("ar_hold", 64'(axi.arvalid), 64'd1);
        axi.arready = 1'b1;
        step();
        chk("ar_drop", 64'(axi.arvalid), 64'd0);
        chk("r_ready", 64'(axi.rready), 64'd1);
        axi.arready = 1'b0;
        step();
        chk("pre_run_res", 64'(core_res), 64'd1);
        axi.rvalid = 1'b1;
        step();
        chk("run_core_res", 64'(core_res), 64'd0);
        chk("run_offset", 64'(core_offset), 64'h1_0000);
        axi.rvalid = 1'b0;

        // Finish: awready 3 cycles late, wready immediate.
        step();
        chk("run_hold", 64'(core_res), 64'd0);
        core_done   = 1'b1;
        axi.wready  = 1'b1;
        step();
        core_done = 1'b0;
        chk("fin_core_res", 64'(core_res), 64'd1);
        chk("fin_aw_w", 64'({axi.awvalid, axi.wvalid}), 64'd3);
        chk("fin_awaddr", 64'(axi.awaddr), PROG);
        chk("fin_wdata", 64'(axi.wdata), 64'd0);
        chk("fin_wstrb", 64'(axi.wstrb), 64'hF);
        step();
        chk("fin_w_drop", 64'({axi.awvalid, axi.wvalid}), 64'd2);
        axi.wready = 1'b0;
        step();
        chk("fin_aw_hold", 64'({axi.awvalid, axi.wvalid}), 64'd2);
        axi.awready = 1'b1;
        step();
        chk("fin_aw_drop", 64'({axi.awvalid, axi.bready}), 64'd1);
        axi.awready = 1'b0;
        step();
        chk("fin_bready", 64'(axi.bready), 64'd1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        step();
        chk("retry_err", 64'(err), 64'd1);
        chk("retry_aw_w", 64'({axi.awvalid, axi.wvalid, axi.bready}),
            64'd6);
        axi.bvalid  = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        step();
        chk("retry_bready", 64'({axi.awvalid, axi.bready}), 64'd1);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b00;
        step();
        axi.bvalid = 1'b0;
        chk("done_bready", 64'(axi.bready), 64'd0);
        chk("done_err", 64'(err), 64'd1);
        chk("done_core_res", 64'(core_res), 64'd1);
        chk("done_offset", 64'(core_offset), 64'h1_0000);
        chk("done_writes", 64'(aw_cnt), 64'd2);
`ifdef NODE_LAUNCHER_COUNT_EN
        chk("cnt_arvalid", 64'(axi.arvalid), 64'd1);
        chk("cnt_araddr", 64'(axi.araddr), CNTA);
        axi.arready = 1'b1;
        step();
        chk("cnt_rready", 64'(axi.rready), 64'd1);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'd1234;
        step();
        axi.rvalid = 1'b0;
        chk("cnt_valid", 64'(run_valid), 64'd1);
        chk("cnt_cycles", 64'(run_cycles), 64'd1234);
        step();
        chk("cnt_pulse", 64'(run_valid), 64'd0);
`else
        chk("done_idle", 64'(axi.arvalid), 64'd0);
`endif

        // Reset while running.
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h0000_2000;
        n = 0;
        while (core_res && n < 20) begin
            step();
            n++;
        end
        chk("reach_run", 64'(core_res), 64'd0);
        chk("run2_offset", 64'(core_offset), 64'h2000);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        res = 1'b1;
        step();
        chk("mid_core_res", 64'(core_res), 64'd1);
        chk("mid_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid,
            axi.rready, axi.bready}), 64'd0);
        chk("mid_offset", 64'(core_offset), 64'd0);
        chk("mid_err", 64'(err), 64'd0);
        res = 1'b0;
        av_any = 1'b0;
        for (int k = 1; k < P; k++) begin
            step();
            av_any = av_any | axi.arvalid;
        end
        chk("mid_quiet", 64'(av_any), 64'd0);
        step();
        chk("mid_arvalid", 64'(axi.arvalid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
